// File: rtl/mem_share_rr_arbiter.sv
// Round-robin read arbiter for one memory-sharing group.
// Grants one requestor per cycle onto the shared memory read port and
// delays the granted ID by the read latency so out_sel steers the output
// switch exactly when that requestor's read data arrives.
// Optional: define MEM_SHARE_ARB_CONFLICT_CNT_EN to add a saturating
// conflict_cnt output counting cycles with two or more competing requests.
module mem_share_rr_arbiter #(
    parameter int SHARED_BANK_NUM = 4,
    parameter int ADDR_WIDTH      = 5,
    parameter int RD_LATENCY      = 1,
    parameter int ID_WIDTH        = $clog2(SHARED_BANK_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [SHARED_BANK_NUM-1:0]          rqst_valid,
    input  logic [SHARED_BANK_NUM*ADDR_WIDTH-1:0] rqst_addr,
    output logic [SHARED_BANK_NUM-1:0]          rqst_ready,
    output logic                                mem_ren,
    output logic [ADDR_WIDTH-1:0]               mem_raddr,
    output logic [ID_WIDTH-1:0]                 out_sel,
    output logic                                out_valid
`ifdef MEM_SHARE_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]                         conflict_cnt
`endif
);

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  grant_found;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [ID_WIDTH-1:0]   pipe_id [RD_LATENCY];

    // Search for the first valid request starting at rr_ptr. SHARED_BANK_NUM
    // is a power of two, so the ID-width addition wraps modulo the group size.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        idx         = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned k = 0; k < SHARED_BANK_NUM; k++) begin
            idx = rr_ptr + ID_WIDTH'(k);
            if (!grant_found && rqst_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
        accept = grant_found && en && !rst;
    end

    // One-hot grant for the winning requestor.
    always_comb begin
        rqst_ready = '0;
        if (accept) begin
            rqst_ready[grant_id] = 1'b1;
        end
    end

    // Address of the winning requestor.
    always_comb begin
        grant_addr = '0;
        for (int unsigned i = 0; i < SHARED_BANK_NUM; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                grant_addr = rqst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Round-robin pointer moves just past the accepted requestor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= grant_id + ID_WIDTH'(1);
        end
    end

    // Issue the accepted read to the shared memory; address holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ren   <= 1'b0;
            mem_raddr <= '0;
        end else begin
            mem_ren <= accept;
            if (accept) begin
                mem_raddr <= grant_addr;
            end
        end
    end

    // Select shift register, filled alongside mem_ren and RD_LATENCY deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int unsigned j = 0; j < RD_LATENCY; j++) begin
                pipe_id[j] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_id[0]    <= grant_id;
            for (int unsigned j = 1; j < RD_LATENCY; j++) begin
                pipe_valid[j] <= pipe_valid[j-1];
                pipe_id[j]    <= pipe_id[j-1];
            end
        end
    end

    // Switch select stage; out_sel keeps its last value when nothing emerges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
        end else begin
            out_valid <= pipe_valid[RD_LATENCY-1];
            if (pipe_valid[RD_LATENCY-1]) begin
                out_sel <= pipe_id[RD_LATENCY-1];
            end
        end
    end

`ifdef MEM_SHARE_ARB_CONFLICT_CNT_EN
    logic multi_rqst;

    // More than one bit set: clearing the lowest set bit leaves something.
    always_comb begin
        multi_rqst = |(rqst_valid & (rqst_valid - SHARED_BANK_NUM'(1)));
    end

    // Saturating count of enabled cycles with competing requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (en && multi_rqst && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_share_rr_arbiter.sv
// Self-checking bench for mem_share_rr_arbiter (N=4, RD_LATENCY=2).
// A history-based model records every accept by cycle number and derives
// each registered output from that history.
module tb_mem_share_rr_arbiter;

    localparam int N    = 4;
    localparam int A    = 5;
    localparam int L    = 2;
    localparam int MAXC = 4096;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   rqst_valid;
    logic [N*A-1:0] rqst_addr;
    logic [N-1:0]   rqst_ready;
    logic           mem_ren;
    logic [A-1:0]   mem_raddr;
    logic [1:0]     out_sel;
    logic           out_valid;
`ifdef MEM_SHARE_ARB_CONFLICT_CNT_EN
    logic [15:0]    conflict_cnt;
`endif

    mem_share_rr_arbiter #(
        .SHARED_BANK_NUM (N),
        .ADDR_WIDTH      (A),
        .RD_LATENCY      (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rqst_valid (rqst_valid),
        .rqst_addr  (rqst_addr),
        .rqst_ready (rqst_ready),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .out_sel    (out_sel),
        .out_valid  (out_valid)
`ifdef MEM_SHARE_ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: accept history indexed by cycle, entries before base discarded.
    int cyc  = 0;
    int base = 0;
    int ptr  = 0;
    int cc   = 0;
    int last_g = -1;
    bit av    [MAXC];
    int aid   [MAXC];
    int aaddr [MAXC];

    // Values sampled from the DUT during the most recent step.
    logic [N-1:0] obs_ready;
    logic         obs_ren;
    logic [A-1:0] obs_raddr;
    logic         obs_ov;
    logic [1:0]   obs_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (!en) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (rqst_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit exp_v(input int j);
        return (j >= base) && (j >= 0) && av[j];
    endfunction

    function automatic int last_val(input int j, input bit want_id);
        for (int k = j; k >= base && k >= 0; k--) begin
            if (av[k]) return want_id ? aid[k] : aaddr[k];
        end
        return 0;
    endfunction

    // One clock cycle: entered just after a negedge with inputs applied.
    task automatic step();
        int g;
        logic [N-1:0] er;
        #1;
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        obs_ready = rqst_ready;
        obs_ren   = mem_ren;
        obs_raddr = mem_raddr;
        obs_ov    = out_valid;
        obs_sel   = out_sel;
        chk("rqst_ready", rqst_ready, er);
        chk("mem_ren",    mem_ren,    exp_v(cyc - 1));
        chk("mem_raddr",  mem_raddr,  last_val(cyc - 1, 1'b0));
        chk("out_valid",  out_valid,  exp_v(cyc - 1 - L));
        chk("out_sel",    out_sel,    last_val(cyc - 1 - L, 1'b1));
`ifdef MEM_SHARE_ARB_CONFLICT_CNT_EN
        chk("conflict_cnt", conflict_cnt, cc);
`endif
        @(posedge clk);
        if (cyc >= MAXC - 1) begin
            $display("FAIL history_overflow cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        av[cyc] = (g >= 0);
        if (g >= 0) begin
            aid[cyc]   = g;
            aaddr[cyc] = int'(rqst_addr[g*A +: A]);
            ptr        = (g + 1) % N;
        end
        if (en && $countones(rqst_valid) >= 2 && cc < 65535) cc++;
        last_g = g;
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        rqst_valid = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_ren",   mem_ren,   0);
        chk("rst_ready",     rqst_ready, 0);
        chk("rst_out_sel",   out_sel,   0);
        chk("rst_mem_raddr", mem_raddr, 0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = cyc;
        ptr  = 0;
        cc   = 0;
        last_g = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d limit=2000000ns", cyc);
        $fatal(1);
    end

    initial begin
        int cnt;
        rst        = 1'b1;
        en         = 1'b0;
        rqst_valid = '0;
        rqst_addr  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // Reset pulse then idle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("idle_ren", obs_ren, 0);
            chk("idle_ov",  obs_ov,  0);
            chk("idle_sel", obs_sel, 0);
        end

        // Single request from requestor 2
        rqst_addr = '0;
        rqst_addr[2*A +: A] = 5'd17;
        rqst_valid = 4'b0100;
        step();
        chk("single_ready", obs_ready, 4'b0100);
        rqst_valid = '0;
        step();
        chk("single_ren",   obs_ren,   1);
        chk("single_raddr", obs_raddr, 17);
        chk("single_ov_t1", obs_ov,    0);
        step();
        chk("single_ov_t2", obs_ov, 0);
        step();
        chk("single_ov_t3",  obs_ov,  1);
        chk("single_sel_t3", obs_sel, 2);
        step();
        chk("single_ov_t4", obs_ov, 0);

        // Fairness with all requestors valid from reset
        do_reset();
        for (int k = 0; k < 12; k++) begin
            rqst_valid = (k < 8) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < N; i++) rqst_addr[i*A +: A] = A'(i * 3 + k);
            step();
            if (k < 8) chk("rr_ready", obs_ready, 32'(1) << (k % 4));
            if (k >= 3 && k <= 10) begin
                chk("rr_ov",  obs_ov,  1);
                chk("rr_sel", obs_sel, (k - 3) % 4);
            end
        end

        // Pointer wrap and skip
        do_reset();
        rqst_valid = 4'b1000; step();
        chk("wrap_g3", obs_ready, 4'b1000);
        rqst_valid = 4'b0011; step();
        chk("wrap_g0", obs_ready, 4'b0001);
        step();
        chk("wrap_g1", obs_ready, 4'b0010);
        rqst_valid = 4'b0010; step();
        chk("again_g1", obs_ready, 4'b0010);

        // en dropped mid-stream: in-flight entries still emerge
        do_reset();
        rqst_valid = 4'b1111;
        repeat (3) step();
        en  = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("en0_ready", obs_ready, 0);
            if (obs_ov) cnt++;
        end
        chk("en0_pulses", cnt, 3);
        en = 1'b1;

        // Reset one cycle after the last accept discards in-flight entries
        rqst_valid = 4'b1111;
        repeat (3) step();
        do_reset();
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_ov) cnt++;
        end
        chk("rst_pulses", cnt, 0);
        rqst_valid = 4'b1111;
        step();
        chk("rst_first_grant", obs_ready, 4'b0001);

        // Randomized traffic with address held until accept
        rqst_valid = '0;
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            for (int i = 0; i < N; i++) begin
                if (rqst_valid[i] && last_g == i) begin
                    rqst_valid[i] = 1'($urandom_range(1, 0));
                    rqst_addr[i*A +: A] = A'($urandom);
                end else if (rqst_valid[i]) begin
                    if ($urandom_range(9, 0) == 0) rqst_valid[i] = 1'b0;
                end else if ($urandom_range(1, 0) == 1) begin
                    rqst_valid[i] = 1'b1;
                    rqst_addr[i*A +: A] = A'($urandom);
                end
            end
            en = ($urandom_range(7, 0) != 0);
            step();
        end
        en = 1'b1;

`ifdef MEM_SHARE_ARB_CONFLICT_CNT_EN
        // Conflict counting and saturation
        do_reset();
        rqst_valid = 4'b0110;
        repeat (5) step();
        rqst_valid = 4'b0001;
        repeat (3) step();
        #1;
        chk("conflict_five", conflict_cnt, 5);
        rqst_valid = 4'b1111;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        #1;
        chk("conflict_sat", conflict_cnt, 16'hFFFF);
        rqst_valid = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
